// File: rtl/tsu_ts_fetch.sv
// tsu_ts_fetch: bus initiator that drains one TX or RX timestamp record
// (seven 32-bit words) from the TSU register block and presents it as a
// single 224-bit record on a valid/ready stream.

`ifndef TSU_BLK_ADDR
`define TSU_BLK_ADDR 24'h00_4000
`endif

module tsu_ts_fetch #(
  parameter logic [23:0] BLK_ADDR = `TSU_BLK_ADDR
) (
  input  logic         bus2ip_clk,
  input  logic         bus2ip_rst,
  input  logic         en_i,
  input  logic         tx_ts_req_i,
  input  logic         rx_ts_req_i,
  output logic [31:0]  bus2ip_addr_o,
  output logic [31:0]  bus2ip_data_o,
  output logic         bus2ip_rd_ce_o,
  output logic         bus2ip_wr_ce_o,
  input  logic [31:0]  ip2bus_data_i,
  output logic         rec_valid_o,
  input  logic         rec_ready_i,
  output logic         rec_dir_o,
  output logic [223:0] rec_data_o,
  output logic [7:0]   drop_cnt_o
);

  // Register offsets inside the TSU block, in record word order.
  localparam logic [7:0] TX_TS_ADDR0   = 8'h10;
  localparam logic [7:0] TX_TS_ADDR1   = 8'h14;
  localparam logic [7:0] TX_TS_ADDR2   = 8'h18;
  localparam logic [7:0] TX_SPF_ADDR0  = 8'h1C;
  localparam logic [7:0] TX_SPF_ADDR1  = 8'h20;
  localparam logic [7:0] TX_SPF_ADDR2  = 8'h24;
  localparam logic [7:0] TX_TVID_ADDR  = 8'h28;
  localparam logic [7:0] RX_TS_ADDR0   = 8'h30;
  localparam logic [7:0] RX_TS_ADDR1   = 8'h34;
  localparam logic [7:0] RX_TS_ADDR2   = 8'h38;
  localparam logic [7:0] RX_SPF_ADDR0  = 8'h3C;
  localparam logic [7:0] RX_SPF_ADDR1  = 8'h40;
  localparam logic [7:0] RX_SPF_ADDR2  = 8'h44;
  localparam logic [7:0] RX_TVID_ADDR  = 8'h48;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]   state;
  logic [2:0]   cnt;
  logic         tx_pend;
  logic         rx_pend;
  logic         dir;
  logic [223:0] rec_data;
  logic [7:0]   drop_cnt;

  logic         start_tx;
  logic         start_rx;
  logic         tx_drop;
  logic         rx_drop;
  logic [8:0]   drop_sum;
  logic         rd_ce;
  logic [7:0]   offset;

  // Fetch start decisions; TX wins when both directions are pending.
  assign start_tx = (state == IDLE) && en_i && tx_pend;
  assign start_rx = (state == IDLE) && en_i && !tx_pend && rx_pend;

  // A request is lost only if its flag is set and not consumed this cycle.
  assign tx_drop  = tx_ts_req_i && tx_pend && !start_tx;
  assign rx_drop  = rx_ts_req_i && rx_pend && !start_rx;
  assign drop_sum = {1'b0, drop_cnt} + {8'd0, tx_drop} + {8'd0, rx_drop};

  assign rd_ce = (state == READ) && (cnt != 3'd7);

  // Offset of the word being read this cycle.
  always_comb begin
    offset = 8'h00;
    if (rd_ce) begin
      case ({dir, cnt})
        4'b0_000: offset = TX_TS_ADDR0;
        4'b0_001: offset = TX_TS_ADDR1;
        4'b0_010: offset = TX_TS_ADDR2;
        4'b0_011: offset = TX_SPF_ADDR0;
        4'b0_100: offset = TX_SPF_ADDR1;
        4'b0_101: offset = TX_SPF_ADDR2;
        4'b0_110: offset = TX_TVID_ADDR;
        4'b1_000: offset = RX_TS_ADDR0;
        4'b1_001: offset = RX_TS_ADDR1;
        4'b1_010: offset = RX_TS_ADDR2;
        4'b1_011: offset = RX_SPF_ADDR0;
        4'b1_100: offset = RX_SPF_ADDR1;
        4'b1_101: offset = RX_SPF_ADDR2;
        4'b1_110: offset = RX_TVID_ADDR;
        default:  offset = 8'h00;
      endcase
    end
  end

  // Pending flags and the saturating drop counter.
  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_rst) begin
      tx_pend  <= 1'b0;
      rx_pend  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (tx_ts_req_i)   tx_pend <= 1'b1;
      else if (start_tx) tx_pend <= 1'b0;
      if (rx_ts_req_i)   rx_pend <= 1'b1;
      else if (start_rx) rx_pend <= 1'b0;
      drop_cnt <= drop_sum[8] ? '1 : drop_sum[7:0];
    end
  end

  // Fetch state machine; words are shifted in so W0 ends up in the top slot
  // after the seventh capture.
  always_ff @(posedge bus2ip_clk) begin
    if (bus2ip_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dir      <= 1'b0;
      rec_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_tx || start_rx) begin
            state <= READ;
            dir   <= start_rx;
          end
        end
        READ: begin
          if (cnt != 3'd0) rec_data <= {rec_data[191:0], ip2bus_data_i};
          if (cnt == 3'd7) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        HOLD: begin
          if (rec_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus2ip_rd_ce_o = rd_ce;
  assign bus2ip_addr_o  = {BLK_ADDR, offset};
  assign bus2ip_data_o  = '0;
  assign bus2ip_wr_ce_o = 1'b0;
  assign rec_valid_o    = (state == HOLD);
  assign rec_dir_o      = dir;
  assign rec_data_o     = rec_data;
  assign drop_cnt_o     = drop_cnt;

endmodule

// File: tb/tb_tsu_ts_fetch.sv
// tb_tsu_ts_fetch: directed stimulus with a record scoreboard and a
// register-slave model for tsu_ts_fetch.

module tb_tsu_ts_fetch;

  localparam logic [23:0] BLK = 24'hA5_C300;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         tx_req;
  logic         rx_req;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         rd_ce;
  logic         wr_ce;
  logic [31:0]  rdata;
  logic         rec_valid;
  logic         rec_ready;
  logic         rec_dir;
  logic [223:0] rec_data;
  logic [7:0]   drop_cnt;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic         dir;
    logic [223:0] data;
  } rec_t;

  rec_t exp_q[$];

  always #5 clk = ~clk;

  tsu_ts_fetch #(.BLK_ADDR(BLK)) dut (
    .bus2ip_clk     (clk),
    .bus2ip_rst     (rst),
    .en_i           (en),
    .tx_ts_req_i    (tx_req),
    .rx_ts_req_i    (rx_req),
    .bus2ip_addr_o  (addr),
    .bus2ip_data_o  (wdata),
    .bus2ip_rd_ce_o (rd_ce),
    .bus2ip_wr_ce_o (wr_ce),
    .ip2bus_data_i  (rdata),
    .rec_valid_o    (rec_valid),
    .rec_ready_i    (rec_ready),
    .rec_dir_o      (rec_dir),
    .rec_data_o     (rec_data),
    .drop_cnt_o     (drop_cnt)
  );

  // Slave model: TX word n at 0x10+4n returns 1000_000n, RX word n at
  // 0x30+4n returns 2000_000n; anything else returns DEAD_BEEF.
  function automatic logic [31:0] slave_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'hDEAD_BEEF;
    if (a[31:8] == BLK) begin
      for (int i = 0; i < 7; i++) begin
        if (a[7:0] == 8'(8'h10 + 4 * i)) w = 32'h1000_0000 + 32'(i);
        if (a[7:0] == 8'(8'h30 + 4 * i)) w = 32'h2000_0000 + 32'(i);
      end
    end
    return w;
  endfunction

  initial rdata = '0;
  always @(posedge clk) if (rd_ce) rdata <= slave_word(addr);

  function automatic rec_t make_rec(input logic d);
    rec_t r;
    logic [31:0] base;
    base   = d ? 32'h2000_0000 : 32'h1000_0000;
    r.dir  = d;
    r.data = {base, base + 32'd1, base + 32'd2, base + 32'd3,
              base + 32'd4, base + 32'd5, base + 32'd6};
    return r;
  endfunction

  task automatic check(input string name, input logic [223:0] act,
                       input logic [223:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops on every accepted record and checks that a
  // record under backpressure never changes.
  initial begin : monitor
    logic         held_v;
    logic [223:0] held_data;
    logic         held_dir;
    rec_t         e;
    held_v = 1'b0;
    held_data = '0;
    held_dir = 1'b0;
    forever begin
      @(negedge clk);
      if (rec_valid && held_v) begin
        check("hold_stable_data", rec_data, held_data);
        check("hold_stable_dir", 224'(rec_dir), 224'(held_dir));
      end
      if (rec_valid && rec_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_record: got dir %0b data %0h expected none",
                   rec_dir, rec_data);
        end else begin
          e = exp_q.pop_front();
          check("rec_dir", 224'(rec_dir), 224'(e.dir));
          check("rec_data", rec_data, e.data);
        end
        held_v = 1'b0;
      end else if (rec_valid) begin
        held_v    = 1'b1;
        held_data = rec_data;
        held_dir  = rec_dir;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; tx_req = 1'b0; rx_req = 1'b0; rec_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rd_ce", 224'(rd_ce), 224'(0));
    check("rst_wr_ce", 224'(wr_ce), 224'(0));
    check("rst_wdata", 224'(wdata), 224'(0));
    check("rst_addr", 224'(addr), 224'({BLK, 8'h00}));
    check("rst_valid", 224'(rec_valid), 224'(0));
    check("rst_dir", 224'(rec_dir), 224'(0));
    check("rst_data", rec_data, 224'(0));
    check("rst_drop", 224'(drop_cnt), 224'(0));

    // Single TX fetch with exact cycle timing.
    tick(1);
    en = 1'b1; rec_ready = 1'b1;
    exp_q.push_back(make_rec(1'b0));
    tx_req = 1'b1;
    tick(1);
    tx_req = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      check($sformatf("tx_rd_ce_j%0d", j), 224'(rd_ce), 224'(j >= 2 && j <= 8));
      check($sformatf("tx_valid_j%0d", j), 224'(rec_valid), 224'(j == 10));
      if (j >= 2 && j <= 8)
        check($sformatf("tx_addr_j%0d", j), 224'(addr), 224'({BLK, 8'(8'h10 + 4 * (j - 2))}));
      else
        check($sformatf("idle_addr_j%0d", j), 224'(addr), 224'({BLK, 8'h00}));
    end
    tick(2);

    // Simultaneous TX and RX: TX first, RX ten cycles later.
    exp_q.push_back(make_rec(1'b0));
    exp_q.push_back(make_rec(1'b1));
    tx_req = 1'b1; rx_req = 1'b1;
    tick(1);
    tx_req = 1'b0; rx_req = 1'b0;
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      check($sformatf("both_valid_j%0d", j), 224'(rec_valid), 224'(j == 10 || j == 20));
      if (j >= 12 && j <= 18)
        check($sformatf("rx_addr_j%0d", j), 224'(addr), 224'({BLK, 8'(8'h30 + 4 * (j - 12))}));
    end
    check("both_drop", 224'(drop_cnt), 224'(0));
    tick(2);

    // Backpressure: three TX pulses while the first record is held.
    rec_ready = 1'b0;
    exp_q.push_back(make_rec(1'b0));
    exp_q.push_back(make_rec(1'b0));
    tx_req = 1'b1; tick(1); tx_req = 1'b0;
    tick(11);
    tx_req = 1'b1; tick(1); tx_req = 1'b0;
    tick(1);
    tx_req = 1'b1; tick(1); tx_req = 1'b0;
    tick(35);
    @(negedge clk);
    check("bp_valid_held", 224'(rec_valid), 224'(1));
    check("bp_no_read", 224'(rd_ce), 224'(0));
    check("bp_drop", 224'(drop_cnt), 224'(1));
    tick(1);
    rec_ready = 1'b1;
    tick(25);
    check("bp_drop_after", 224'(drop_cnt), 224'(1));

    // Saturation: en low so the flag stays set and further pulses drop.
    en = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tx_req = 1'b1; tick(1); tx_req = 1'b0; tick(1);
    end
    check("sat_mid", 224'(drop_cnt), 224'(11));
    for (int k = 0; k < 290; k++) begin
      tx_req = 1'b1; tick(1); tx_req = 1'b0; tick(1);
    end
    check("sat_full", 224'(drop_cnt), 224'(255));
    tx_req = 1'b1; tick(1); tx_req = 1'b0; tick(1);
    check("sat_hold", 224'(drop_cnt), 224'(255));

    // Reset clears the drop count and the pending TX flag.
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rst2_drop", 224'(drop_cnt), 224'(0));
    en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("rst2_no_fetch", 224'(rd_ce), 224'(0));
    end
    tick(1);

    // Disabled with RX pending: no reads until en rises.
    en = 1'b0;
    rx_req = 1'b1; tick(1); rx_req = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("dis_no_rd", 224'(rd_ce), 224'(0));
      tick(1);
    end
    exp_q.push_back(make_rec(1'b1));
    en = 1'b1;
    @(negedge clk);
    check("en_same_cycle", 224'(rd_ce), 224'(0));
    tick(1);
    @(negedge clk);
    check("en_next_rd_ce", 224'(rd_ce), 224'(1));
    check("en_next_addr", 224'(addr), 224'({BLK, 8'h30}));
    tick(15);

    // Reset at cnt=3 of a TX fetch with RX also pending.
    tx_req = 1'b1; rx_req = 1'b1; tick(1);
    tx_req = 1'b0; rx_req = 1'b0;
    tick(4);
    @(negedge clk);
    check("mid_rd_ce_before", 224'(rd_ce), 224'(1));
    check("mid_addr_before", 224'(addr), 224'({BLK, 8'h1C}));
    rst = 1'b1; tick(1); rst = 1'b0;
    @(negedge clk);
    check("mid_rd_ce_after", 224'(rd_ce), 224'(0));
    check("mid_valid_after", 224'(rec_valid), 224'(0));
    for (int j = 0; j < 20; j++) begin
      tick(1);
      @(negedge clk);
      check("mid_no_rd", 224'(rd_ce), 224'(0));
      check("mid_no_rec", 224'(rec_valid), 224'(0));
    end

    check("scoreboard_empty", 224'(exp_q.size()), 224'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
